// File: rtl/mips_decode_if.sv
// mips_decode_if: decode-stage bus between Fetch/WriteBack (master side)
// and the decode unit (slave side). Carries the instruction, write-back data,
// register operands, the immediate and all control outputs.
interface mips_decode_if;
  logic [31:0] instruction;
  logic [31:0] wr_data;
  logic [31:0] rd_out1;
  logic [31:0] rd_out2;
  logic [31:0] sign_extend;
  logic        RegDest;
  logic        Jump;
  logic        Branch;
  logic        MemRead;
  logic        MemtoReg;
  logic        MemWrite;
  logic        ALUSrc;
  logic        RegWrite;
  logic [1:0]  ALUOp;
  logic [3:0]  FunctC;

  // Driver side: supplies instruction and write-back data, consumes decode.
  modport master (
    output instruction, wr_data,
    input  rd_out1, rd_out2, sign_extend,
    input  RegDest, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
    input  ALUOp, FunctC
  );

  // Decode unit side.
  modport slave (
    input  instruction, wr_data,
    output rd_out1, rd_out2, sign_extend,
    output RegDest, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
    output ALUOp, FunctC
  );
endinterface

// File: rtl/mips_decode_unit.sv
// mips_decode_unit: single-cycle MIPS decode stage. Main control decoder,
// ALU-control decoder, 32x32 register file (async read, sync write, $0 hard
// zero) and immediate sign extension.
// Optional feature: define DECODE_WRITE_BYPASS_EN to forward wr_data onto a
// read port in the same cycle when it targets the register being read.
module mips_decode_unit (
  input  logic        clk,
  input  logic        reset,
  mips_decode_if.slave dec_if
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [4:0]  wr_addr;
  logic        we_d;
  logic [31:0] regs_q [32];
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign opcode  = dec_if.instruction[31:26];
  assign rs_addr = dec_if.instruction[25:21];
  assign rt_addr = dec_if.instruction[20:16];
  assign rd_addr = dec_if.instruction[15:11];
  assign funct   = dec_if.instruction[5:0];

  // Main control decode; anything unrecognised (including X) falls to the
  // all-zero default so it can never enable a register write.
  always_comb begin
    dec_if.RegDest  = 1'b0;
    dec_if.ALUSrc   = 1'b0;
    dec_if.MemtoReg = 1'b0;
    dec_if.RegWrite = 1'b0;
    dec_if.MemRead  = 1'b0;
    dec_if.MemWrite = 1'b0;
    dec_if.Branch   = 1'b0;
    dec_if.Jump     = 1'b0;
    dec_if.ALUOp    = 2'b00;
    case (opcode)
      OP_RTYPE: begin
        dec_if.RegDest  = 1'b1;
        dec_if.RegWrite = 1'b1;
        dec_if.ALUOp    = 2'b10;
      end
      OP_LW: begin
        dec_if.ALUSrc   = 1'b1;
        dec_if.MemtoReg = 1'b1;
        dec_if.RegWrite = 1'b1;
        dec_if.MemRead  = 1'b1;
      end
      OP_SW: begin
        dec_if.ALUSrc   = 1'b1;
        dec_if.MemWrite = 1'b1;
      end
      OP_BEQ: begin
        dec_if.Branch   = 1'b1;
        dec_if.ALUOp    = 2'b01;
      end
      OP_ADDI: begin
        dec_if.ALUSrc   = 1'b1;
        dec_if.RegWrite = 1'b1;
      end
      OP_J: begin
        dec_if.Jump     = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU control: class code from the main decoder, funct refines R-type.
  always_comb begin
    dec_if.FunctC = 4'b1111;
    case (dec_if.ALUOp)
      2'b00: dec_if.FunctC = 4'b0010;
      2'b01: dec_if.FunctC = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000: dec_if.FunctC = 4'b0010;
          6'b100010: dec_if.FunctC = 4'b0110;
          6'b100100: dec_if.FunctC = 4'b0000;
          6'b100101: dec_if.FunctC = 4'b0001;
          6'b101010: dec_if.FunctC = 4'b0111;
          6'b100111: dec_if.FunctC = 4'b1100;
          default:   dec_if.FunctC = 4'b1111;
        endcase
      end
      default: dec_if.FunctC = 4'b1111;
    endcase
  end

  assign dec_if.sign_extend = {{16{dec_if.instruction[15]}}, dec_if.instruction[15:0]};

  // Destination select and write enable; $0 writes and reset-cycle writes
  // are suppressed here so the storage never sees them.
  assign wr_addr = dec_if.RegDest ? rd_addr : rt_addr;
  assign we_d    = dec_if.RegWrite && (wr_addr != 5'd0) && !reset;

  // Register file storage: synchronous clear, otherwise single write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (we_d) begin
      regs_q[wr_addr] <= dec_if.wr_data;
    end
  end

  // Asynchronous reads; $0 is forced to zero regardless of storage.
  assign rs_val = (rs_addr == 5'd0) ? 32'd0 : regs_q[rs_addr];
  assign rt_val = (rt_addr == 5'd0) ? 32'd0 : regs_q[rt_addr];

`ifdef DECODE_WRITE_BYPASS_EN
  logic byp_rs;
  logic byp_rt;
  // Same-cycle forwarding of the write-back value onto matching read ports.
  always_comb begin
    byp_rs = dec_if.RegWrite && (wr_addr != 5'd0) && (wr_addr == rs_addr);
    byp_rt = dec_if.RegWrite && (wr_addr != 5'd0) && (wr_addr == rt_addr);
    dec_if.rd_out1 = byp_rs ? dec_if.wr_data : rs_val;
    dec_if.rd_out2 = byp_rt ? dec_if.wr_data : rt_val;
  end
`else
  assign dec_if.rd_out1 = rs_val;
  assign dec_if.rd_out2 = rt_val;
`endif

endmodule

// File: tb/tb_mips_decode_unit.sv
// tb_mips_decode_unit: directed vectors with hand-computed expectations pushed
// into a scoreboard queue; a negedge monitor pops and compares DUT outputs.
module tb_mips_decode_unit;
  logic clk;
  logic reset;
  mips_decode_if dif ();

  mips_decode_unit dut (.clk(clk), .reset(reset), .dec_if(dif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [13:0] ctrl;  // RegDest,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOp,FunctC
    logic [31:0] sext;
    logic [31:0] rd1;
    logic [31:0] rd2;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Expected read value when the register being read is also being written.
  function automatic logic [31:0] byp(input logic [31:0] stored, input logic [31:0] wd);
`ifdef DECODE_WRITE_BYPASS_EN
    return wd;
`else
    return stored;
`endif
  endfunction

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
  endtask

  // Monitor: outputs are combinational, so every cycle with a queued
  // expectation is a presented response.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "ctrl", {18'd0, dif.RegDest, dif.ALUSrc, dif.MemtoReg, dif.RegWrite,
                           dif.MemRead, dif.MemWrite, dif.Branch, dif.Jump,
                           dif.ALUOp, dif.FunctC}, {18'd0, e.ctrl});
      chk(e.name, "sext", dif.sign_extend, e.sext);
      chk(e.name, "rd1",  dif.rd_out1, e.rd1);
      chk(e.name, "rd2",  dif.rd_out2, e.rd2);
    end
  end

  task automatic vec(input string nm, input logic rst, input logic [31:0] ins,
                     input logic [31:0] wd, input logic [13:0] ctrl,
                     input logic [31:0] sx, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    dif.instruction = ins;
    dif.wr_data = wd;
    e.name = nm; e.ctrl = ctrl; e.sext = sx; e.rd1 = r1; e.rd2 = r2;
    q.push_back(e);
  endtask

  localparam logic [13:0] C_ADD = 14'b1001_0000_10_0010;
  localparam logic [13:0] C_LW  = 14'b0111_1000_00_0010;
  localparam logic [13:0] C_SW  = 14'b0100_0100_00_0010;
  localparam logic [13:0] C_BEQ = 14'b0000_0010_01_0110;
  localparam logic [13:0] C_ADI = 14'b0101_0000_00_0010;
  localparam logic [13:0] C_J   = 14'b0000_0001_00_0010;
  localparam logic [13:0] C_NOP = 14'b0000_0000_00_0010;

  initial begin
    reset = 1'b1;
    dif.instruction = 32'd0;
    dif.wr_data = 32'd0;
    repeat (2) @(posedge clk);
    // reset held: add $7 write must be dropped
    vec("rst_add",   1, 32'h00A63820, 32'h00001234, C_ADD,                32'h00003820, 0, 0);
    // read rs=5/rt=7 after reset; R-type with rd=0 tries to write $0
    vec("rd0_wr",    0, 32'h00A70000, 32'hFFFFFFFF, 14'b1001_0000_10_1111, 32'h0, 0, 0);
    vec("add_7",     0, 32'h00A63820, 32'h00001234, C_ADD,                32'h00003820, 0, 0);
    // sw reads $0 (still 0) and $7 (0x1234); no write of 0xDEAD
    vec("sw",        0, 32'hAC070004, 32'h0000DEAD, C_SW,                 32'h4, 0, 32'h1234);
    vec("lw",        0, 32'h8C880004, 32'h00005555, C_LW,                 32'h4, 0, byp(0, 32'h5555));
    vec("lw_neg",    0, 32'h8CE8FFFC, 32'h0000A5A5, C_LW,                 32'hFFFFFFFC, 32'h1234, byp(32'h5555, 32'hA5A5));
    vec("beq",       0, 32'h10E80010, 32'h00000BAD, C_BEQ,                32'h10, 32'h1234, 32'hA5A5);
    vec("addi_9",    0, 32'h20098000, 32'hCAFEBABE, C_ADI,                32'hFFFF8000, 0, byp(0, 32'hCAFEBABE));
    vec("and",       0, 32'h01275024, 32'h00000F0F, 14'b1001_0000_10_0000, 32'h5024, 32'hCAFEBABE, 32'h1234);
    vec("or",        0, 32'h01400025, 32'hFFFFFFFF, 14'b1001_0000_10_0001, 32'h25, 32'h0F0F, 0);
    vec("slt",       0, 32'h0000002A, 32'hFFFFFFFF, 14'b1001_0000_10_0111, 32'h2A, 0, 0);
    vec("nor",       0, 32'h00000027, 32'hFFFFFFFF, 14'b1001_0000_10_1100, 32'h27, 0, 0);
    vec("bad_funct", 0, 32'h0000003F, 32'hFFFFFFFF, 14'b1001_0000_10_1111, 32'h3F, 0, 0);
    vec("j",         0, 32'h08000010, 32'h00000777, C_J,                  32'h10, 0, 0);
    vec("bad_op",    0, 32'hFC0B0000, 32'h00000777, C_NOP,                32'h0, 0, 0);
    // $11 untouched by the unknown opcode; $0 untouched by rd=0 writes
    vec("chk_11",    0, 32'h016A0020, 32'h00000000, C_ADD,                32'h20, 0, 32'h0F0F);
    // mid-stream reset with a pending write to $7
    vec("rst_mid",   1, 32'h00A63820, 32'h00009999, C_ADD,                32'h00003820, 0, 0);
    vec("post_rst",  0, 32'hACEA0000, 32'h00000000, C_SW,                 32'h0, 0, 0);
    // bounded drain of the scoreboard
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
